// File: rtl/rr_resp_demux_if.sv
// rr_resp_demux_if: bundles the handshake buses around rr_resp_demux.
//   push_*      : grant record from the arbiter (index of the forwarded request)
//   rsp_*_i     : downstream response stream in (rsp_ready_o is its ready)
//   rsp_*_o     : per-port valid plus broadcast data/last toward the initiators
//                 (rsp_ready_i carries the per-port readies)
// The slave modport is the demux's view; master is the surrounding logic's view.
interface rr_resp_demux_if #(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = $clog2(NumOut)
);
  logic                 push_valid_i;
  logic [IdxWidth-1:0]  push_idx_i;
  logic                 push_ready_o;
  logic                 rsp_valid_i;
  logic                 rsp_ready_o;
  logic [DataWidth-1:0] rsp_data_i;
  logic                 rsp_last_i;
  logic [NumOut-1:0]    rsp_valid_o;
  logic [NumOut-1:0]    rsp_ready_i;
  logic [DataWidth-1:0] rsp_data_o;
  logic                 rsp_last_o;

  modport slave (
    input  push_valid_i, push_idx_i, rsp_valid_i, rsp_data_i, rsp_last_i, rsp_ready_i,
    output push_ready_o, rsp_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o
  );

  modport master (
    output push_valid_i, push_idx_i, rsp_valid_i, rsp_data_i, rsp_last_i, rsp_ready_i,
    input  push_ready_o, rsp_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o
  );
endinterface

// File: rtl/rr_resp_demux.sv
// rr_resp_demux: records the arbiter's grant order in a circular FIFO and steers
// each returning response burst to the port at the FIFO head; the head is popped
// on the beat that carries rsp_last_i.
// Ports:
//   clk_i, rst_ni (synchronous, active-low), flush_i (synchronous clear)
//   bus      : rr_resp_demux_if.slave (push and response handshakes)
//   count_o  : number of outstanding entries
//   err_o    : sticky protocol error
// Optional feature: define RR_RESP_DEMUX_ERR_EN to build the sticky error flag
// (response while empty, push while full). Otherwise err_o is constant 0.
module rr_resp_demux #(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 8,
  parameter int unsigned IdxWidth  = $clog2(NumOut),
  parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  rr_resp_demux_if.slave      bus,
  output logic [CntWidth-1:0] count_o,
  output logic                err_o
);

  localparam int unsigned         PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0] PtrMax   = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] CntFull  = CntWidth'(Depth);

  logic [Depth-1:0][IdxWidth-1:0] mem_q, mem_d;
  logic [PtrWidth-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]            count_q, count_d;

  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  logic [IdxWidth-1:0] head_s;
  logic [NumOut-1:0]   valid_s;
  logic                ready_s;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrMax) begin
      return {PtrWidth{1'b0}};
    end else begin
      return p + PtrWidth'(1);
    end
  endfunction

  // FIFO status and head index.
  always_comb begin
    full_s  = (count_q == CntFull);
    empty_s = (count_q == {CntWidth{1'b0}});
    head_s  = mem_q[rd_ptr_q];
  end

  // Route the response beat to the head port; stall the stream when empty.
  always_comb begin
    valid_s = {NumOut{1'b0}};
    ready_s = 1'b0;
    if (!empty_s) begin
      valid_s[head_s] = bus.rsp_valid_i;
      ready_s         = bus.rsp_ready_i[head_s];
    end else begin
      valid_s = {NumOut{1'b0}};
      ready_s = 1'b0;
    end
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    push_s   = bus.push_valid_i & ~full_s;
    pop_s    = bus.rsp_valid_i & ready_s & bus.rsp_last_i;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PtrWidth{1'b0}};
      rd_ptr_d = {PtrWidth{1'b0}};
      count_d  = {CntWidth{1'b0}};
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = bus.push_idx_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PtrWidth{1'b0}};
      rd_ptr_q <= {PtrWidth{1'b0}};
      count_q  <= {CntWidth{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only read while count_q says they are valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifdef RR_RESP_DEMUX_ERR_EN
  logic err_q, err_d;

  // Sticky error: response with nothing outstanding, or push while full.
  always_comb begin
    if (flush_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | (bus.rsp_valid_i & empty_s) | (bus.push_valid_i & full_s);
    end
  end

  // Error flag register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign bus.push_ready_o = ~full_s;
  assign bus.rsp_valid_o  = valid_s;
  assign bus.rsp_ready_o  = ready_s;
  assign bus.rsp_data_o   = bus.rsp_data_i;
  assign bus.rsp_last_o   = bus.rsp_last_i;
  assign count_o          = count_q;

endmodule
